// File: rtl/s2p_fifo_pkg.sv
// Shared types and constants for the serial-to-parallel receive FIFO.
// The S2P_PARITY_EN macro adds the parity state to the state enum.
package s2p_fifo_pkg;

    localparam int MAX_FIFO_DEPTH = 8;
    localparam int MAX_FIFO_WIDTH = 11;
    localparam int MAX_NUM_LOOPS  = 6;

    localparam int BIT_CNT_W = $clog2(MAX_FIFO_WIDTH + 1);
    localparam int PTR_W     = $clog2(MAX_FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    // Legal ranges of the runtime configuration inputs.
    localparam int SIG_DEPTH_MIN = 2;
    localparam int SIG_DEPTH_MAX = 8;
    localparam int SIG_WIDTH_MIN = 8;
    localparam int SIG_WIDTH_MAX = 11;
    localparam int SIG_LOOPS_MIN = 3;
    localparam int SIG_LOOPS_MAX = 6;

    typedef enum logic [1:0] {
        S_BITS = 2'd0,
`ifdef S2P_PARITY_EN
        S_PAR  = 2'd1,
`endif
        S_HOLD = 2'd2
    } s2p_state_t;

    // Pointer advance that wraps at the runtime depth rather than the storage size.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                 input logic [3:0]       depth);
        if ({1'b0, ptr} == depth - 4'd1) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

endpackage

// File: rtl/sig_fifo_core.sv
// Show-ahead FIFO whose effective depth is selected at runtime by sig_depth.
module sig_fifo_core
    import s2p_fifo_pkg::*;
#(
    parameter int DEPTH = MAX_FIFO_DEPTH,
    parameter int WIDTH = MAX_FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic [3:0]       sig_depth,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(sig_depth));
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_en  = push && (!full || pop);
        pop_en   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q, sig_depth);
        end
        if (pop_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q, sig_depth);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/s2p_fifo_with_sig.sv
// Serial-to-parallel receive FIFO: MSB-first deserializer, word accumulator, result FIFO.
// Define S2P_PARITY_EN to expect an even-parity bit after every word.
module s2p_fifo_with_sig
    import s2p_fifo_pkg::*;
#(
    parameter int max_FIFO_DEPTH = MAX_FIFO_DEPTH,
    parameter int max_FIFO_WIDTH = MAX_FIFO_WIDTH,
    parameter int max_NUM_LOOPS  = MAX_NUM_LOOPS,
    parameter int max_ADD_MODE   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ser_valid,
    input  logic                              ser_data,
    output logic                              ser_ready,
    input  logic                              pop,
    output logic [max_FIFO_WIDTH-1:0]         pop_data,
    output logic                              empty,
    output logic                              full,
    output logic                              parity_err,
    input  logic [3:0]                        sig_FIFO_DEPTH,
    input  logic [3:0]                        sig_FIFO_WIDTH,
    input  logic [$clog2(max_NUM_LOOPS):0]    sig_NUM_LOOPS,
    input  logic                              sig_ADD_MODE
);

    localparam int  W         = max_FIFO_WIDTH;
    localparam int  NL_W      = $clog2(max_NUM_LOOPS) + 1;
    localparam bit  ADD_BUILT = (max_ADD_MODE != 0);

    s2p_state_t           state_q, state_d;
    logic [W-1:0]         shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [NL_W-1:0]      loop_cnt_q, loop_cnt_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [W-1:0]         stage_q, stage_d;

    logic [W-1:0]         width_mask;
    logic [W-1:0]         shift_next;
    logic [W-1:0]         word_val;
    logic [W-1:0]         acc_new;
    logic                 close_word;
    logic                 accept;
    logic                 room;
    logic                 add_en;
    logic                 push;
    logic [W-1:0]         push_data;

`ifdef S2P_PARITY_EN
    logic                 parity_err_q, parity_err_d;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign ser_ready  = (state_q != S_HOLD);
    assign accept     = ser_valid && ser_ready;
    assign room       = !full || pop;
    assign add_en     = ADD_BUILT && sig_ADD_MODE;
    assign shift_next = {shift_q[W-2:0], ser_data};

    always_comb begin
        for (int i = 0; i < W; i++) begin
            width_mask[i] = (i < int'(sig_FIFO_WIDTH));
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        loop_cnt_d = loop_cnt_q;
        acc_d      = acc_q;
        stage_d    = stage_q;
        close_word = 1'b0;
        word_val   = '0;
        acc_new    = '0;
        push       = 1'b0;
        push_data  = stage_q;
`ifdef S2P_PARITY_EN
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_BITS: begin
                if (accept) begin
                    if (bit_cnt_q == BIT_CNT_W'(sig_FIFO_WIDTH) - BIT_CNT_W'(1)) begin
                        bit_cnt_d = '0;
`ifdef S2P_PARITY_EN
                        shift_d   = shift_next;
                        state_d   = S_PAR;
`else
                        shift_d    = '0;
                        close_word = 1'b1;
                        word_val   = shift_next & width_mask;
`endif
                    end else begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef S2P_PARITY_EN
            S_PAR: begin
                if (accept) begin
                    shift_d = '0;
                    state_d = S_BITS;
                    // Even parity: word bits plus parity bit must XOR to zero.
                    if ((^shift_q) ^ ser_data) begin
                        parity_err_d = 1'b1;
                    end else begin
                        close_word = 1'b1;
                        word_val   = shift_q & width_mask;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (room) begin
                    push      = 1'b1;
                    push_data = stage_q;
                    state_d   = S_BITS;
                end
            end
            default: state_d = S_BITS;
        endcase

        if (close_word) begin
            acc_new = add_en ? ((acc_q + word_val) & width_mask) : word_val;
            if (loop_cnt_q == sig_NUM_LOOPS - NL_W'(1)) begin
                loop_cnt_d = '0;
                acc_d      = '0;
                if (room) begin
                    push      = 1'b1;
                    push_data = acc_new;
                end else begin
                    stage_d = acc_new;
                    state_d = S_HOLD;
                end
            end else begin
                loop_cnt_d = loop_cnt_q + NL_W'(1);
                acc_d      = acc_new;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BITS;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            loop_cnt_q <= '0;
            acc_q      <= '0;
            stage_q    <= '0;
`ifdef S2P_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            loop_cnt_q <= loop_cnt_d;
            acc_q      <= acc_d;
            stage_q    <= stage_d;
`ifdef S2P_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    sig_fifo_core #(
        .DEPTH (max_FIFO_DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .sig_depth (sig_FIFO_DEPTH),
        .pop_data  (pop_data),
        .empty     (empty),
        .full      (full)
    );

endmodule

// File: tb/tb_s2p_fifo_with_sig.sv
// Self-checking bench for s2p_fifo_with_sig: directed cases plus randomized configurations
// against a queue-based reference model.
module tb_s2p_fifo_with_sig;
    import s2p_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_valid = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_ready;
    logic        pop = 1'b0;
    logic [10:0] pop_data;
    logic        empty;
    logic        full;
    logic        parity_err;
    logic [3:0]  sig_FIFO_DEPTH = 4'd8;
    logic [3:0]  sig_FIFO_WIDTH = 4'd8;
    logic [3:0]  sig_NUM_LOOPS  = 4'd3;
    logic        sig_ADD_MODE   = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    int          model_q[$];
    int          cur_depth, cur_width, cur_loops, cur_mode;
    logic [10:0] words [6];

    always #5 clk = ~clk;

    s2p_fifo_with_sig dut (
        .clk            (clk),
        .rst            (rst),
        .ser_valid      (ser_valid),
        .ser_data       (ser_data),
        .ser_ready      (ser_ready),
        .pop            (pop),
        .pop_data       (pop_data),
        .empty          (empty),
        .full           (full),
        .parity_err     (parity_err),
        .sig_FIFO_DEPTH (sig_FIFO_DEPTH),
        .sig_FIFO_WIDTH (sig_FIFO_WIDTH),
        .sig_NUM_LOOPS  (sig_NUM_LOOPS),
        .sig_ADD_MODE   (sig_ADD_MODE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every status output against the model; call at a negedge.
    task automatic check_status(input string tag);
        int occ;
        occ = model_q.size();
        check({tag, ".empty"},      32'(empty),      32'(occ == 0));
        check({tag, ".full"},       32'(full),       32'(occ >= cur_depth));
        check({tag, ".ser_ready"},  32'(ser_ready),  32'(occ <= cur_depth));
        check({tag, ".pop_data"},   32'(pop_data),   (occ > 0) ? 32'(model_q[0]) : 32'd0);
        check({tag, ".parity_err"}, 32'(parity_err), 32'd0);
    endtask

    task automatic do_reset(input int depth, input int width, input int loops, input int mode);
        @(negedge clk);
        rst            = 1'b1;
        ser_valid      = 1'b0;
        pop            = 1'b0;
        sig_FIFO_DEPTH = 4'(depth);
        sig_FIFO_WIDTH = 4'(width);
        sig_NUM_LOOPS  = 4'(loops);
        sig_ADD_MODE   = 1'(mode);
        cur_depth = depth;
        cur_width = width;
        cur_loops = loops;
        cur_mode  = mode;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
    endtask

    task automatic send_bit(input logic b);
        int waited;
        waited = 0;
        @(negedge clk);
        ser_valid = 1'b1;
        ser_data  = b;
        while (!ser_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ser_ready) begin
            check("ready_timeout", 32'(ser_ready), 32'd1);
            ser_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ser_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [10:0] w, input bit bad_parity);
        for (int i = cur_width - 1; i >= 0; i--) begin
            send_bit(w[i]);
        end
`ifdef S2P_PARITY_EN
        send_bit((^w) ^ bad_parity);
`else
        if (bad_parity) $display("note: parity corruption requested without parity build");
`endif
    endtask

    // Reference result of one group of words: modular sum or last word.
    function automatic int expected_result();
        int sum;
        sum = 0;
        for (int k = 0; k < cur_loops; k++) sum += int'(words[k]);
        return cur_mode ? (sum % (1 << cur_width)) : int'(words[cur_loops - 1]);
    endfunction

    task automatic send_result();
        for (int k = 0; k < cur_loops; k++) send_word(words[k], 1'b0);
        model_q.push_back(expected_result());
    endtask

    task automatic pop_entry();
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        do_reset(8, 8, 3, 1);
        @(negedge clk);
        check_status("reset");

        // Sum of three 8-bit words.
        words[0] = 11'h10; words[1] = 11'h20; words[2] = 11'h30;
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        @(negedge clk);
        check("sum3.before_last", 32'(empty), 32'd1);
        send_word(words[2], 1'b0);
        model_q.push_back(expected_result());
        @(negedge clk);
        check("sum3.result", 32'(pop_data), 32'h60);
        check_status("sum3");
        pop_entry();
        @(negedge clk);
        check_status("sum3.popped");

        // Pop while empty is ignored.
        pop_entry();
        @(negedge clk);
        check_status("pop_empty");

        // Modular wrap at width 11.
        do_reset(8, 11, 4, 1);
        for (int k = 0; k < 4; k++) words[k] = 11'h7FF;
        send_result();
        @(negedge clk);
        check("wrap11.result", 32'(pop_data), 32'h7FC);
        check_status("wrap11");

        // Last-word mode.
        do_reset(8, 8, 3, 0);
        words[0] = 11'h11; words[1] = 11'h22; words[2] = 11'h33;
        send_result();
        @(negedge clk);
        check("last.result", 32'(pop_data), 32'h33);
        check_status("last");

        // Depth 2: third result is staged and back-pressures the serial input.
        do_reset(2, 8, 3, 1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) words[k] = 11'(8 * r + k + 1);
            send_result();
            @(negedge clk);
            check_status($sformatf("hold.r%0d", r));
        end
        check("hold.ready_low", 32'(ser_ready), 32'd0);
        pop_entry();
        @(negedge clk);
        check("hold.ready_back", 32'(ser_ready), 32'd1);
        check_status("hold.pop1");
        pop_entry();
        @(negedge clk);
        check_status("hold.pop2");
        pop_entry();
        @(negedge clk);
        check_status("hold.pop3");

`ifdef S2P_PARITY_EN
        // Corrupted parity on the second word: pulse, word dropped, replacement counted.
        do_reset(8, 8, 3, 1);
        send_word(11'h05, 1'b0);
        send_word(11'h66, 1'b1);
        @(negedge clk);
        check("par.pulse", 32'(parity_err), 32'd1);
        @(negedge clk);
        check("par.pulse_end", 32'(parity_err), 32'd0);
        send_word(11'h07, 1'b0);
        @(negedge clk);
        check("par.not_yet", 32'(empty), 32'd1);
        send_word(11'h09, 1'b0);
        model_q.push_back(32'h15);
        @(negedge clk);
        check("par.result", 32'(pop_data), 32'h15);
        check_status("par");
`endif

        // Reset mid-word discards FIFO contents and the partial word.
        do_reset(8, 8, 3, 1);
        words[0] = 11'h01; words[1] = 11'h02; words[2] = 11'h03;
        send_result();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        do_reset(8, 8, 3, 1);
        @(negedge clk);
        check_status("midreset");
        words[0] = 11'h0A; words[1] = 11'h0B; words[2] = 11'h0C;
        send_result();
        @(negedge clk);
        check("midreset.result", 32'(pop_data), 32'h21);
        check_status("midreset.after");

        // Randomized configurations checked against the queue model.
        for (int it = 0; it < 8; it++) begin
            int depth, width, loops, mode, nres;
            depth = SIG_DEPTH_MIN << $urandom_range(0, 2);
            width = $urandom_range(SIG_WIDTH_MIN, SIG_WIDTH_MAX);
            loops = $urandom_range(SIG_LOOPS_MIN, SIG_LOOPS_MAX);
            mode  = $urandom_range(0, 1);
            do_reset(depth, width, loops, mode);
            nres = $urandom_range(1, depth);
            for (int r = 0; r < nres; r++) begin
                for (int k = 0; k < loops; k++) words[k] = 11'($urandom & ((1 << width) - 1));
                send_result();
                @(negedge clk);
                check_status($sformatf("rand%0d.res%0d", it, r));
                if ($urandom_range(0, 1) == 1) begin
                    pop_entry();
                    @(negedge clk);
                    check_status($sformatf("rand%0d.pop%0d", it, r));
                end
            end
            while (model_q.size() > 0) begin
                pop_entry();
                @(negedge clk);
                check_status($sformatf("rand%0d.drain", it));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/s2p_fifo_with_sig.md
# s2p_fifo_with_sig

Serial-to-parallel receive FIFO: the receiving end of the parallel-to-serial FIFO link. It deserializes an MSB-first bit stream into words of a runtime-selected width, combines `sig_NUM_LOOPS` consecutive words into one result according to `sig_ADD_MODE`, and buffers the results in a FIFO of runtime-selected depth. Compile-time `max_*` parameters size the storage; the `sig_*` inputs select the active configuration.

## Interface
- `max_FIFO_DEPTH`, 8: storage entries; power of two.
- `max_FIFO_WIDTH`, 11: storage word width.
- `max_NUM_LOOPS`, 6: maximum words combined per result.
- `max_ADD_MODE`, 1: when 0, add mode is compiled out and `sig_ADD_MODE` is ignored.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ser_valid` in 1: serial bit valid.
- `ser_data` in 1: serial bit, MSB first.
- `ser_ready` out 1: bit accepted on an edge where `ser_valid && ser_ready`.
- `pop` in 1: dequeue the head entry.
- `pop_data` out `max_FIFO_WIDTH`: head entry (show-ahead); bits at and above `sig_FIFO_WIDTH` read 0.
- `empty` out 1, `full` out 1: FIFO status against `sig_FIFO_DEPTH`.
- `parity_err` out 1: one-cycle pulse on a parity mismatch.
- `sig_FIFO_DEPTH` in 4: legal values 2, 4, 8.
- `sig_FIFO_WIDTH` in 4: legal values 8 to 11.
- `sig_NUM_LOOPS` in `$clog2(max_NUM_LOOPS)+1`: legal values 3 to 6.
- `sig_ADD_MODE` in 1: 1 = sum, 0 = last word.
- The `sig_*` inputs are stable whenever `rst` is low. A change while out of reset is illegal and its behaviour is undefined.

## Operation
- State machine states:
  - `S_BITS`: shift in bits. After the `sig_FIFO_WIDTH`-th bit, go to `S_PAR` (macro enabled) or close the word (macro disabled).
  - `S_PAR`: accept one parity bit, then close the word.
  - `S_HOLD`: a result is staged and the FIFO is full.
- Closing a word:
  - Increment `loop_cnt`.
  - Combine into the accumulator: `ADD_MODE=1` gives `acc = (acc + word) mod 2^sig_FIFO_WIDTH`; `ADD_MODE=0` gives `acc = word`.
- When `loop_cnt` reaches `sig_NUM_LOOPS`, push `acc` into the FIFO, then clear `acc` and `loop_cnt`.
- If the push is blocked (full and no same-cycle pop): stage the result, enter `S_HOLD`, deassert `ser_ready`. Leave `S_HOLD` on the first edge where room exists, pushing the staged result.
- `ser_ready` is 1 in `S_BITS` and `S_PAR`, and 0 in `S_HOLD`.
- Pushing and popping:
  - A push is accepted when `!full || pop`.
  - `pop` while `empty` is ignored; pointers are unchanged.
  - Simultaneous push and pop keeps the occupancy count unchanged.
- Pointers wrap modulo `sig_FIFO_DEPTH`. `full` is asserted when the count equals `sig_FIFO_DEPTH`.

## Timing
- Reset values: `ser_ready=1`, `pop_data=0`, `empty=1`, `full=0`, `parity_err=0`. State `S_BITS`; all counters, the accumulator and the pointers are 0.
- Latency: the edge that accepts the final bit of the last loop writes the FIFO (when there is room). `empty` falls and `pop_data` is valid in the cycle after that edge.
- `pop_data` is combinational from the head entry. A pop on edge N presents the next entry after edge N.
- Reset asserted mid-word or in `S_HOLD` discards all partial and staged data and all FIFO contents within one edge.
- `S_HOLD` to `S_BITS`: `ser_ready` rises in the cycle after the push edge.

## Configuration
- `S2P_PARITY_EN` defined:
  - Each word is followed by one even-parity bit, handled in `S_PAR`.
  - On a mismatch the word is excluded from `acc` and does not count toward `loop_cnt`.
  - `parity_err` pulses in the cycle after the parity bit is accepted.
- `S2P_PARITY_EN` undefined: no `S_PAR` state, no parity bit, and `parity_err` is tied to 0.

## Structure
- Package `s2p_fifo_pkg` holds:
  - the state enum `s2p_state_t`;
  - the widths `BIT_CNT_W = $clog2(max_FIFO_WIDTH+1)` and `PTR_W`;
  - the legal-value constants for the `sig_*` inputs.
- One sub-module, `sig_fifo_core`: storage, pointers, `full`/`empty` against `sig_FIFO_DEPTH`, show-ahead read.
- The top level holds the deserializer FSM, the accumulator and the staging register.

## Test plan
- Config 8/8/3/1, serial words 0x10, 0x20, 0x30 → one entry 0x60; `empty` falls the cycle after the last bit.
- Config 8/11/4/1, four words of 0x7FF → `pop_data = 0x7FC` (wrap modulo 2^11).
- Config 8/8/3/0, words 0x11, 0x22, 0x33 → `pop_data = 0x33`.
- Depth 2, no pops, third result completes → `full=1`, `ser_ready=0`. `pop` on the next edge → staged result is pushed and `ser_ready=1` a cycle later.
- `S2P_PARITY_EN` with a corrupted parity bit on word 2 → `parity_err` pulses and the result only completes after a replacement word.
- Reset asserted after 5 bits of a word → `empty=1`, and the next word assembles from bit 0.
